// File: rtl/led_matrix_driver.sv
// Red/green PWM dot-matrix scanner with a ROWS x COLS frame buffer and read-back port.
// Define LED_SELFTEST_EN to add the post-reset four-phase red/green flash self-test.
module led_matrix_driver #(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int BPC          = 4,
  parameter int ROW_CYCLES   = 1024,
  parameter int BLANK_CYCLES = 16,
  parameter int FLASH_CYCLES = 50_000_000
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   disp_en,
  input  logic                                   wr_en,
  input  logic [$clog2(ROWS)-1:0]                wr_row,
  input  logic [(COLS > 1 ? $clog2(COLS) : 1)-1:0] wr_col,
  input  logic [BPC-1:0]                         wr_r,
  input  logic [BPC-1:0]                         wr_g,
  input  logic [$clog2(ROWS)-1:0]                rd_row,
  input  logic [(COLS > 1 ? $clog2(COLS) : 1)-1:0] rd_col,
  output logic [BPC-1:0]                         rd_r,
  output logic [BPC-1:0]                         rd_g,
  output logic [ROWS-1:0]                        row_n,
  output logic [COLS-1:0]                        col_r,
  output logic [COLS-1:0]                        col_g,
  output logic                                   frame_start,
  output logic                                   busy
);
  localparam int RW = $clog2(ROWS);
  localparam int DW = $clog2(ROW_CYCLES);
  localparam logic [DW-1:0] BLANK_LEN  = DW'(BLANK_CYCLES);
  localparam logic [DW-1:0] BLANK_LAST = DW'(BLANK_CYCLES - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(ROW_CYCLES - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

  logic [BPC-1:0]  buf_red_r [ROWS][COLS];
  logic [BPC-1:0]  buf_grn_r [ROWS][COLS];
  logic [BPC-1:0]  lat_red_r [COLS];
  logic [BPC-1:0]  lat_grn_r [COLS];
  logic [DW-1:0]   dwell_r;
  logic [RW-1:0]   row_r;
  logic [BPC-1:0]  pwm_s;
  logic [ROWS-1:0] row_n_s;
  logic [COLS-1:0] col_r_s;
  logic [COLS-1:0] col_g_s;
  logic            wr_ok_s;
  logic            rd_ok_s;
  logic            run_s;
  logic            st_red_s;
  logic            st_grn_s;

`ifdef LED_SELFTEST_EN
  typedef enum logic [2:0] {ST_R0, ST_G0, ST_R1, ST_G1, RUN} state_t;
  localparam int FW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_CYCLES - 1);
  localparam logic BUSY_RST = 1'b1;

  state_t        state_r;
  state_t        state_s;
  logic [FW-1:0] flash_r;
  logic          flash_done_s;

  assign flash_done_s = (flash_r == FLASH_LAST);

  // Self-test state register and per-phase flash timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_R0;
      flash_r <= '0;
    end else begin
      state_r <= state_s;
      if (state_r == RUN || flash_done_s) begin
        flash_r <= '0;
      end else begin
        flash_r <= flash_r + 1'b1;
      end
    end
  end

  // Phase sequencing and per-state pin mode selection
  always_comb begin
    state_s  = state_r;
    run_s    = 1'b0;
    st_red_s = 1'b0;
    st_grn_s = 1'b0;
    case (state_r)
      ST_R0: begin
        st_red_s = 1'b1;
        if (flash_done_s) state_s = ST_G0; else state_s = ST_R0;
      end
      ST_G0: begin
        st_grn_s = 1'b1;
        if (flash_done_s) state_s = ST_R1; else state_s = ST_G0;
      end
      ST_R1: begin
        st_red_s = 1'b1;
        if (flash_done_s) state_s = ST_G1; else state_s = ST_R1;
      end
      ST_G1: begin
        st_grn_s = 1'b1;
        if (flash_done_s) state_s = RUN; else state_s = ST_G1;
      end
      RUN:     run_s   = 1'b1;
      default: state_s = ST_R0;
    endcase
  end
`else
  localparam logic BUSY_RST = 1'b0;

  assign run_s    = 1'b1;
  assign st_red_s = 1'b0;
  assign st_grn_s = 1'b0;
`endif

  assign wr_ok_s = wr_en && (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);
  assign rd_ok_s = (int'(rd_row) < ROWS) && (int'(rd_col) < COLS);
  assign pwm_s   = BPC'(dwell_r - BLANK_LEN);

  // Frame buffer write port; reset clears every pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          buf_red_r[r][c] <= '0;
          buf_grn_r[r][c] <= '0;
        end
      end
    end else if (wr_ok_s) begin
      buf_red_r[wr_row][wr_col] <= wr_r;
      buf_grn_r[wr_row][wr_col] <= wr_g;
    end
  end

  // Registered read-back port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_r <= '0;
      rd_g <= '0;
    end else if (rd_ok_s) begin
      rd_r <= buf_red_r[rd_row][rd_col];
      rd_g <= buf_grn_r[rd_row][rd_col];
    end else begin
      rd_r <= '0;
      rd_g <= '0;
    end
  end

  // Dwell and row scan counters, parked at zero outside RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_r <= '0;
      row_r   <= '0;
    end else if (!run_s) begin
      dwell_r <= '0;
      row_r   <= '0;
    end else if (dwell_r == DWELL_LAST) begin
      dwell_r <= '0;
      row_r   <= (row_r == ROW_LAST) ? '0 : row_r + 1'b1;
    end else begin
      dwell_r <= dwell_r + 1'b1;
    end
  end

  // Row latch snapshots the buffer on the last blank cycle (pre-write value on a collision)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < COLS; c++) begin
        lat_red_r[c] <= '0;
        lat_grn_r[c] <= '0;
      end
    end else if (run_s && dwell_r == BLANK_LAST) begin
      for (int c = 0; c < COLS; c++) begin
        lat_red_r[c] <= buf_red_r[row_r][c];
        lat_grn_r[c] <= buf_grn_r[row_r][c];
      end
    end
  end

  // Next pin pattern: self-test flash, blank window, or PWM active window
  always_comb begin
    row_n_s = '1;
    col_r_s = '0;
    col_g_s = '0;
    if (st_red_s) begin
      row_n_s = '0;
      col_r_s = '1;
    end else if (st_grn_s) begin
      row_n_s = '0;
      col_g_s = '1;
    end else if (run_s && disp_en && dwell_r >= BLANK_LEN) begin
      row_n_s[row_r] = 1'b0;
      for (int c = 0; c < COLS; c++) begin
        col_r_s[c] = (lat_red_r[c] > pwm_s);
        col_g_s[c] = (lat_grn_r[c] > pwm_s);
      end
    end else begin
      row_n_s = '1;
    end
  end

  // Registered pin, frame marker and busy outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_n       <= '1;
      col_r       <= '0;
      col_g       <= '0;
      frame_start <= 1'b0;
      busy        <= BUSY_RST;
    end else begin
      row_n       <= row_n_s;
      col_r       <= col_r_s;
      col_g       <= col_g_s;
      frame_start <= run_s && (dwell_r == '0) && (row_r == '0);
      busy        <= !run_s;
    end
  end
endmodule

// File: doc/led_matrix_driver.md
# led_matrix_driver

Parametrised multi-channel LED dot-matrix driver with per-pixel, per-channel PWM brightness. It owns a ROWS×COLS frame buffer with a write port and a read-back port. It scans rows with a programmable dwell, inserts a blanking gap before each row to suppress ghosting, and drives row-low / column-high matrix pins. It sits between the pen/state-machine logic, which writes pixels, and the board pins. It replaces the fixed 8×8 on/off-plus-dim driver.

## Interface
- ROWS, 8, matrix rows (≥2)
- COLS, 8, matrix columns (≥1)
- BPC, 4, brightness bits per colour channel (1..8)
- ROW_CYCLES, 1024, clocks each row is selected, including blanking
- BLANK_CYCLES, 16, clocks at the start of each row dwell with all pins off (≥2, < ROW_CYCLES − 2^BPC)
- FLASH_CYCLES, 50_000_000, clocks per self-test phase
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- disp_en  in  1  display enable; 0 forces pins off while scanning continues
- wr_en  in  1  write strobe, one pixel per cycle
- wr_row  in  $clog2(ROWS)  write row address
- wr_col  in  $clog2(COLS)  write column address
- wr_r, wr_g  in  BPC each  red / green brightness to write
- rd_row, rd_col  in  as wr_*  read-back address
- rd_r, rd_g  out  BPC each  read-back pixel, registered
- row_n  out  ROWS  row drive, active-low
- col_r, col_g  out  COLS each  column drive, active-high
- frame_start  out  1  one-cycle pulse at the start of each frame
- busy  out  1  self-test in progress

## Operation
- Frame buffer: ROWS×COLS entries of {r,g}, 2·BPC bits each, register array, all zero on reset. Out-of-range wr addresses are ignored. Out-of-range rd addresses return 0.
- Scan counters: `dwell` counts 0..ROW_CYCLES−1. `row` increments when `dwell` wraps and wraps from ROWS−1 to 0.
- Row latch: on `dwell == BLANK_CYCLES−1`, all COLS pixels of `row` are copied to a row latch. If a write to the same row happens in that cycle, the latch takes the pre-write value. The new value shows on the next scan of that row.
- Blank window, `dwell < BLANK_CYCLES`: row_n all 1s, col_r/col_g all 0s.
- Active window: `pwm = (dwell − BLANK_CYCLES) mod 2^BPC`.
  - row_n[row] = 0; all other row_n bits = 1.
  - col_r[c] = (latch_r[c] > pwm); col_g[c] likewise.
  - Value 0 is always off. Value 2^BPC−1 is on for (2^BPC−1) of every 2^BPC clocks.
- disp_en = 0 forces the blank pattern. Counters, latch and frame_start are unaffected.
- Normal states: RUN only. With self-test compiled in: ST_R0 → ST_G0 → ST_R1 → ST_G1 → RUN.
  - Each ST_* state lasts FLASH_CYCLES.
  - In ST_R*: row_n all 0s, col_r all 1s, col_g all 0s.
  - In ST_G*: col_g all 1s, col_r all 0s.
  - Scan counters are held at 0 during ST_*.
  - disp_en is ignored during self-test.
  - Writes and reads work normally during self-test.

## Timing
- Reset values:
  - row_n all 1s; col_r, col_g all 0s
  - frame_start 0; rd_r, rd_g 0
  - busy 1 if self-test is compiled in, else 0
  - state ST_R0 if self-test is compiled in, else RUN
  - counters 0
- All pin outputs are registered: the pin state at cycle t+1 reflects the counters and latch at cycle t.
- Write at cycle t (wr_en=1) updates the buffer at the edge ending cycle t. A read of that address issued in cycle t+1 returns the new value at t+2.
- Read latency is 1 cycle from rd_row/rd_col to rd_r/rd_g.
- frame_start is high for exactly 1 cycle, coincident on the outputs with the first blank cycle of row 0, then every ROWS·ROW_CYCLES clocks. The first pulse is 1 cycle after RUN is entered.
- busy falls in the same output cycle as the first RUN-state pin update.
- Asserting rst_n low mid-frame or mid-self-test immediately forces the reset values above, including clearing the buffer.

## Configuration
- LED_SELFTEST_EN defined: the four-phase red/green/red/green flash runs after every reset, and busy reflects it.
- LED_SELFTEST_EN undefined: the ST_* states and the flash counter are absent. busy is tied 0. The FSM starts in RUN and scanning begins on the first clock after reset release.

## Test plan
All scenarios use ROWS=4, COLS=4, BPC=2, ROW_CYCLES=16, BLANK_CYCLES=4, FLASH_CYCLES=8.

- Reset release with LED_SELFTEST_EN: busy=1 for 32 clocks. Pins show col_r=4'hF for 8 clocks, then col_g=4'hF for 8, then repeat; row_n=0 throughout. Then busy=0 and frame_start pulses.
- Write (1,2) r=3, g=1; then wait for row 1 active: col_r[2] high 3 of every 4 clocks, col_g[2] high 1 of every 4 clocks. All blank cycles are fully off. row_n=4'b1101 in the active window.
- Read-back after write at cycle t: rd_r=3, rd_g=1 at t+2. Read of (3,3), never written: 0.
- Write to row 2 in the exact latch cycle of row 2: the old value is driven this scan and the new value on the next scan, 64 clocks later.
- disp_en=0 mid-row: pins all off from the next cycle. frame_start still pulses every 64 clocks. On disp_en=1, scan resumes in phase.
- rst_n pulsed low in the middle of row 3: outputs go to reset values immediately and the buffer reads 0.
